// File: rtl/kronos_xif_scheduler.sv
// KRONOS X-IF scheduler: buffers accepted instructions in issue order, tracks commit/kill,
// and drives the Keccak round engine for each committed instruction before returning a result.
module kronos_xif_scheduler #(
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4,
    parameter int ROUNDS = 24
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic            issue_is_kronos_i,
    input  logic [ID_W-1:0] issue_id_i,
    output logic            issue_accept_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            eng_init_o,
    output logic            eng_round_en_o,
    output logic [4:0]      eng_round_idx_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic            busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [ID_W-1:0]  ent_id [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_committed;
    logic [DEPTH-1:0] ent_killed;
    logic [4:0]       round_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             push_commit;

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    // Ready is held low while reset is applied so every output reads 0 during reset.
    assign issue_ready_o  = !full && !rst_i;
    assign issue_accept_o = issue_valid_i && issue_ready_o && issue_is_kronos_i;
    assign push           = issue_accept_o;
    assign push_commit    = commit_valid_i && (commit_id_i == issue_id_i);

    // Next-state and pop decision.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && ent_committed[rd_idx]) begin
                    if (ent_killed[rd_idx]) begin
                        pop = 1'b1;
                    end else begin
                        state_next = INIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            INIT: begin
                state_next = ROUND;
            end
            ROUND: begin
                if (round_cnt == LAST_ROUND) begin
                    state_next = RESP;
                end else begin
                    state_next = ROUND;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round counter: cleared while loading the engine, advanced once per round.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            round_cnt <= 5'd0;
        end else if (state == INIT) begin
            round_cnt <= 5'd0;
        end else if (state == ROUND) begin
            round_cnt <= round_cnt + 5'd1;
        end else begin
            round_cnt <= round_cnt;
        end
    end

    // Instruction buffer: commit/kill marking, push at the tail, pop at the head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ent_valid     <= '0;
            ent_committed <= '0;
            ent_killed    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && ent_valid[i] && !ent_committed[i] &&
                    (ent_id[i] == commit_id_i)) begin
                    ent_committed[i] <= 1'b1;
                    ent_killed[i]    <= commit_kill_i;
                end
            end
            // A commit arriving with its own issue lands in the entry as it is written.
            if (push) begin
                ent_id[wr_idx]        <= issue_id_i;
                ent_valid[wr_idx]     <= 1'b1;
                ent_committed[wr_idx] <= push_commit;
                ent_killed[wr_idx]    <= push_commit && commit_kill_i;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_valid[rd_idx] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
        end
    end

    assign eng_init_o      = (state == INIT);
    assign eng_round_en_o  = (state == ROUND);
    assign eng_round_idx_o = (state == ROUND) ? round_cnt : 5'd0;
    assign result_valid_o  = (state == RESP);
    // The head is not popped until the handshake, so the ID stays stable while waiting.
    assign result_id_o     = (state == RESP) ? ent_id[rd_idx] : '0;
    assign busy_o          = !empty || (state != IDLE);

endmodule

// File: tb/tb_kronos_xif_scheduler.sv
// Self-checking bench for kronos_xif_scheduler: scenario tasks plus a result scoreboard.
module tb_kronos_xif_scheduler;

    localparam int ID_W   = 4;
    localparam int DEPTH  = 4;
    localparam int ROUNDS = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic            issue_ready;
    logic            issue_is_kronos;
    logic [ID_W-1:0] issue_id;
    logic            issue_accept;
    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic            commit_kill;
    logic            eng_init;
    logic            eng_round_en;
    logic [4:0]      eng_round_idx;
    logic            result_valid;
    logic            result_ready;
    logic [ID_W-1:0] result_id;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int exp_round = 0;
    int init_cnt = 0;
    logic [ID_W-1:0] exp_q[$];

    kronos_xif_scheduler #(.ID_W(ID_W), .DEPTH(DEPTH), .ROUNDS(ROUNDS)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_is_kronos_i(issue_is_kronos), .issue_id_i(issue_id),
        .issue_accept_o(issue_accept),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .eng_init_o(eng_init), .eng_round_en_o(eng_round_en), .eng_round_idx_o(eng_round_idx),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_id_o(result_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Monitor: round index sequence and result scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (eng_init) begin
            exp_round = 0;
            init_cnt++;
        end
        if (eng_round_en) begin
            tests++;
            if (eng_round_idx !== 5'(exp_round)) begin
                fails++;
                $display("FAIL round_idx: got %0d expected %0d", eng_round_idx, exp_round);
            end
            exp_round++;
        end
        if (result_valid && result_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL result_unexpected: got id %0d expected none", result_id);
            end else begin
                logic [ID_W-1:0] e;
                e = exp_q.pop_front();
                if (result_id !== e) begin
                    fails++;
                    $display("FAIL result_id: got %0d expected %0d", result_id, e);
                end
            end
            tests++;
            if (exp_round !== ROUNDS) begin
                fails++;
                $display("FAIL round_count: got %0d expected %0d", exp_round, ROUNDS);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [ID_W-1:0] id);
        issue_valid = 1'b1; issue_is_kronos = 1'b1; issue_id = id;
        @(negedge clk);
        tests++;
        if (issue_accept !== 1'b1) begin
            fails++;
            $display("FAIL issue_accept id %0d: got %b expected 1", id, issue_accept);
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic commit_op(input logic [ID_W-1:0] id, input logic kill);
        commit_valid = 1'b1; commit_id = id; commit_kill = kill;
        tick();
        commit_valid = 1'b0; commit_kill = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_timeout: busy %b expected 0", name, busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        tests++;
        if ({issue_ready, issue_accept, eng_init, eng_round_en, eng_round_idx,
             result_valid, result_id, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy%b init%b ren%b idx%0d rv%b rid%0d busy%b expected all 0",
                     issue_ready, eng_init, eng_round_en, eng_round_idx, result_valid, result_id, busy);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got ready %b busy %b expected 1 0", issue_ready, busy);
        end
        tick();
    endtask

    task automatic test_single_op();
        int n;
        int i0;
        i0 = init_cnt;
        result_ready = 1'b0;
        issue_op(4'd3);
        exp_q.push_back(4'd3);
        commit_op(4'd3, 1'b0);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (result_valid === 1'b1) break;
        end
        tests++;
        if (n !== ROUNDS + 3) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles expected %0d", n, ROUNDS + 3);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            tests++;
            if (result_valid !== 1'b1 || result_id !== 4'd3) begin
                fails++;
                $display("FAIL single_hold: got valid %b id %0d expected 1 3", result_valid, result_id);
            end
        end
        tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got busy %b valid %b expected 0 0", busy, result_valid);
        end
        tests++;
        if (init_cnt - i0 !== 1) begin
            fails++;
            $display("FAIL single_inits: got %0d expected 1", init_cnt - i0);
        end
        tick();
    endtask

    task automatic test_fill();
        int n;
        int i0;
        i0 = init_cnt;
        result_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) issue_op(4'(k));
        @(negedge clk);
        tests++;
        if (issue_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: got ready %b expected 0", issue_ready);
        end
        issue_valid = 1'b1; issue_is_kronos = 1'b1; issue_id = 4'd4;
        @(negedge clk);
        tests++;
        if (issue_accept !== 1'b0) begin
            fails++;
            $display("FAIL fill_stall: got accept %b expected 0", issue_accept);
        end
        exp_q.push_back(4'd0);
        tick();
        commit_op(4'd0, 1'b0);
        n = 0;
        while (n < 100 && issue_accept !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (issue_accept !== 1'b1) begin
            fails++;
            $display("FAIL fill_accept5: got accept %b expected 1", issue_accept);
        end
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (issue_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_refull: got ready %b expected 0", issue_ready);
        end
        for (int k = 1; k <= DEPTH; k++) commit_op(4'(k), 1'b1);
        wait_idle(50, "fill");
        tests++;
        if (init_cnt - i0 !== 1) begin
            fails++;
            $display("FAIL fill_inits: got %0d expected 1", init_cnt - i0);
        end
    endtask

    task automatic test_kill_order();
        int i0;
        i0 = init_cnt;
        result_ready = 1'b1;
        issue_op(4'd1);
        issue_op(4'd2);
        issue_op(4'd3);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        commit_op(4'd2, 1'b1);
        commit_op(4'd3, 1'b0);
        commit_op(4'd1, 1'b0);
        wait_idle(200, "kill");
        tests++;
        if (init_cnt - i0 !== 2 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL kill_order: got inits %0d pending %0d expected 2 0", init_cnt - i0, exp_q.size());
        end
    endtask

    task automatic test_same_cycle();
        result_ready = 1'b1;
        issue_valid = 1'b1; issue_is_kronos = 1'b1; issue_id = 4'd5;
        commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b0;
        exp_q.push_back(4'd5);
        @(negedge clk);
        tests++;
        if (issue_accept !== 1'b1) begin
            fails++;
            $display("FAIL same_accept: got %b expected 1", issue_accept);
        end
        tick();
        issue_valid = 1'b0; commit_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (eng_init !== 1'b0) begin
            fails++;
            $display("FAIL same_init_early: got %b expected 0", eng_init);
        end
        tick();
        @(negedge clk);
        tests++;
        if (eng_init !== 1'b1) begin
            fails++;
            $display("FAIL same_init: got %b expected 1", eng_init);
        end
        wait_idle(100, "same");
    endtask

    task automatic test_non_kronos();
        issue_valid = 1'b1; issue_is_kronos = 1'b0; issue_id = 4'd7;
        @(negedge clk);
        tests++;
        if (issue_ready !== 1'b1 || issue_accept !== 1'b0) begin
            fails++;
            $display("FAIL nonk_handshake: got ready %b accept %b expected 1 0", issue_ready, issue_accept);
        end
        tick();
        issue_valid = 1'b0;
        commit_op(4'd9, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || eng_init !== 1'b0) begin
                fails++;
                $display("FAIL nonk_idle: got busy %b init %b expected 0 0", busy, eng_init);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        result_ready = 1'b1;
        issue_op(4'd6);
        commit_op(4'd6, 1'b0);
        n = 0;
        @(negedge clk);
        while (n < 100 && !(eng_round_en === 1'b1 && eng_round_idx === 5'd10)) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (eng_round_idx !== 5'd10) begin
            fails++;
            $display("FAIL mid_reach10: got idx %0d expected 10", eng_round_idx);
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if ({issue_ready, issue_accept, eng_init, eng_round_en, eng_round_idx,
             result_valid, result_id, busy} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got ren%b idx%0d rv%b busy%b expected all 0",
                     eng_round_en, eng_round_idx, result_valid, busy);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || issue_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_after: got busy %b ready %b expected 0 1", busy, issue_ready);
        end
        tick();
        issue_op(4'd8);
        exp_q.push_back(4'd8);
        commit_op(4'd8, 1'b0);
        wait_idle(100, "mid");
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_is_kronos = 1'b0; issue_id = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b0;
        test_reset();
        test_single_op();
        test_fill();
        test_kill_order();
        test_same_cycle();
        test_non_kronos();
        test_reset_mid();
        repeat (3) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kronos_xif_scheduler.md
Name: kronos_xif_scheduler

Overview:
- Sequencing controller between the CV-X-IF issue/commit/result channels and the KRONOS Keccak permutation datapath.
- Accepts KRONOS instructions, buffers them in issue order, and waits for each one's commit or kill.
- For each committed instruction, in order: drives the round engine through ROUNDS rounds, then returns a result tagged with the instruction ID.
- Killed instructions are retired silently and never start the engine.

Parameters:
- ID_W, 4: width of X-IF instruction ID.
- DEPTH, 4: outstanding-instruction buffer entries; power of 2, ≥2.
- ROUNDS, 24: permutation rounds per instruction; ≤32.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  synchronous reset, active-high.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  scheduler can take an issue.
- issue_is_kronos_i  in  1  decoder flag: instruction targets KRONOS.
- issue_id_i  in  ID_W  instruction ID.
- issue_accept_o  out  1  instruction accepted (combinational).
- commit_valid_i  in  1  commit transaction valid.
- commit_id_i  in  ID_W  committed/killed ID.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- eng_init_o  out  1  one-cycle pulse: engine loads state.
- eng_round_en_o  out  1  engine performs one round this cycle.
- eng_round_idx_o  out  5  current round index (round-constant select).
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  ID_W  ID of the returned result.
- busy_o  out  1  buffer non-empty or FSM not IDLE.

Behaviour:
- Reset: all outputs 0, buffer empty, FSM in IDLE, round counter 0. Reset mid-operation drops all in-flight and buffered instructions; no result is emitted for them.
- issue_ready_o = !full; no same-cycle pop bypass.
- issue_accept_o = issue_valid_i & issue_ready_o & issue_is_kronos_i.
- Each accept pushes entry {id, committed=0, killed=0}.
- A valid issue with issue_is_kronos_i=0 is handshaken (ready still 1) but not accepted and not pushed.
- Commit: the entry whose id == commit_id_i and committed==0 gets committed=1, plus killed=1 if commit_kill_i.
  - Same-cycle commit for the ID being accepted: the entry is pushed with those flags already set.
  - No matching entry: ignored.
  - Entry already committed: ignored.
- Outstanding IDs are unique by X-IF protocol; duplicate-ID behaviour is unspecified.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty uses an extra wrap bit.
- FSM states:
  - IDLE: head valid & committed & killed → pop, stay IDLE (1 cycle per killed entry). Head valid & committed & !killed → INIT. Otherwise stay IDLE.
  - INIT: eng_init_o=1 for 1 cycle; round counter cleared → ROUND.
  - ROUND: eng_round_en_o=1, eng_round_idx_o = counter. Counter increments each cycle. On counter == ROUNDS-1 → RESP. Exactly ROUNDS cycles spent in ROUND.
  - RESP: result_valid_o=1, result_id_o = head id. Both are held stable until result_ready_i. On handshake → pop head, go to IDLE.
- Latency: commit in cycle t of an uncommitted head while IDLE → eng_init_o in t+2, rounds in t+3..t+2+ROUNDS, result_valid_o from t+3+ROUNDS.
- Outputs are registered/decoded from state only, except issue_ready_o and issue_accept_o (combinational from buffer state and inputs).
- eng_round_idx_o = 0 outside ROUND.
- Issue, commit and pop may all occur in one cycle. Push and pop on the same cycle keep the occupancy unchanged.
- Kill can only target uncommitted entries; an executing head is always committed, so it is never aborted.
- busy_o = !empty | (state != IDLE).

Test Plan:
- Single op: issue id=3, commit id=3 (kill=0) next cycle → eng_init_o pulse, 24 eng_round_en_o cycles with idx 0..23, result_valid_o with result_id_o=3; ready held low 5 cycles → valid/id stable; busy_o falls after handshake.
- Fill: issue ids 0..3 without commit → issue_ready_o=0 after 4th accept. 5th issue stalls; commit id 0 → after result handshake ready rises and the 5th issue is accepted.
- Kill ordering: issue 1,2,3; kill 2, commit 3, commit 1 → results exactly id 1 then id 3; id 2 never on result_id_o, engine started twice.
- Same-cycle issue+commit id=5 → entry treated as committed; eng_init_o exactly 2 cycles later.
- Non-KRONOS issue (is_kronos=0) → issue_accept_o=0, busy_o stays 0; stray commit id=9 with empty buffer → no effect.
- Reset asserted at round 10 → next cycle all outputs 0, buffer empty. A subsequent issue/commit sequence runs normally from round idx 0.
